// File: rtl/lbm_pkg.sv
// lbm_pkg: shared word format, D2Q9 velocity tables and FSM states for lbm_moments
package lbm_pkg;
  localparam int WIDTH = 32;
  localparam int FBITS = 24;
  localparam int Q = 9;
  localparam int EX [Q] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  localparam int EY [Q] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
  typedef enum logic [2:0] {ACC, SAT, DX_START, DX_WAIT, DY_START, DY_WAIT, DONE} state_t;
endpackage

// File: rtl/lbm_moments.sv
// lbm_moments: D2Q9 moments (rho, ux, uy) from 9 f_in beats; in_valid/in_ready in, div_* to a shared fp_div, out_valid/out_ready result
module lbm_moments
  import lbm_pkg::*;
#(
  parameter int WIDTH = lbm_pkg::WIDTH,
  parameter int FBITS = lbm_pkg::FBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] f_in,
  output logic             div_start,
  output logic [WIDTH-1:0] div_x,
  output logic [WIDTH-1:0] div_y,
  input  logic             div_busy,
  input  logic             div_valid,
  input  logic             div_dbz,
  input  logic             div_ovf,
  input  logic [WIDTH-1:0] div_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rho,
  output logic [WIDTH-1:0] ux,
  output logic [WIDTH-1:0] uy,
  output logic             err_dbz,
  output logic             err_ovf
);
  localparam int AW = WIDTH + 4;
  localparam logic signed [AW-1:0] HI = {5'b00000, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] LO = {5'b11111, {(WIDTH-1){1'b0}}};
  if (FBITS < 0 || FBITS >= WIDTH) begin : g_bad_fbits
    $error("FBITS must lie in [0, WIDTH)");
  end
  state_t st, nxt;
  logic [3:0] idx;
  logic signed [AW-1:0] acc_rho, acc_mx, acc_my, fx, tx, ty;
  logic [WIDTH-1:0] mx, my, res;
  logic [WIDTH:0] sr, sx, sy;
  logic in_dx, in_dy;
  // {clamped, value}: saturate a wide accumulator into the signed word range
  function automatic logic [WIDTH:0] clamp(input logic signed [AW-1:0] a);
    return a > HI ? {1'b1, HI[WIDTH-1:0]} : a < LO ? {1'b1, LO[WIDTH-1:0]} : {1'b0, a[WIDTH-1:0]};
  endfunction
  assign fx = {{4{f_in[WIDTH-1]}}, f_in};
  assign tx = EX[idx] > 0 ? fx : EX[idx] < 0 ? -fx : '0;
  assign ty = EY[idx] > 0 ? fx : EY[idx] < 0 ? -fx : '0;
  assign sr = clamp(acc_rho);
  assign sx = clamp(acc_mx);
  assign sy = clamp(acc_my);
  assign res = div_dbz ? '0 : div_q;
  assign in_dx = st == DX_START || st == DX_WAIT;
  assign in_dy = st == DY_START || st == DY_WAIT;
  assign in_ready = st == ACC;
  assign out_valid = st == DONE;
  assign div_start = (st == DX_START || st == DY_START) && !div_busy;
  // operands derive from registered state, so they hold steady until div_valid
  assign div_x = in_dx ? mx : in_dy ? my : '0;
  assign div_y = in_dx || in_dy ? rho : '0;
  always_comb begin
    nxt = st;
    case (st)
      ACC:      nxt = in_valid && idx == 4'd8 ? SAT : ACC;
      SAT:      nxt = sr[WIDTH-1:0] == '0 ? DONE : DX_START;
      DX_START: nxt = div_busy ? DX_START : DX_WAIT;
      DX_WAIT:  nxt = div_valid ? DY_START : DX_WAIT;
      DY_START: nxt = div_busy ? DY_START : DY_WAIT;
      DY_WAIT:  nxt = div_valid ? DONE : DY_WAIT;
      DONE:     nxt = out_ready ? ACC : DONE;
      default:  nxt = ACC;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst || (st == DONE && out_ready)) begin
      st <= ACC;
      idx <= '0;
      acc_rho <= '0;
      acc_mx <= '0;
      acc_my <= '0;
      rho <= '0;
      mx <= '0;
      my <= '0;
      ux <= '0;
      uy <= '0;
      err_dbz <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      st <= nxt;
      if (st == ACC && in_valid) begin
        idx <= idx == 4'd8 ? 4'd0 : idx + 4'd1;
        acc_rho <= acc_rho + fx;
        acc_mx <= acc_mx + tx;
        acc_my <= acc_my + ty;
      end
      if (st == SAT) begin
        rho <= sr[WIDTH-1:0];
        mx <= sx[WIDTH-1:0];
        my <= sy[WIDTH-1:0];
        err_ovf <= sr[WIDTH] | sx[WIDTH] | sy[WIDTH];
        err_dbz <= sr[WIDTH-1:0] == '0;
      end
      if (st == DX_WAIT && div_valid) begin
        ux <= res;
        err_ovf <= err_ovf | div_ovf;
        err_dbz <= err_dbz | div_dbz;
      end
      if (st == DY_WAIT && div_valid) begin
        uy <= res;
        err_ovf <= err_ovf | div_ovf;
        err_dbz <= err_dbz | div_dbz;
      end
    end
  end
endmodule

// File: tb/tb_lbm_moments.sv
// tb_lbm_moments: randomized self-checking bench for lbm_moments with a behavioural divider and moment model
module tb_lbm_moments;
  localparam int W = 32;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [W-1:0] f_in = '0;
  logic in_ready, div_start, out_valid, err_dbz, err_ovf;
  logic [W-1:0] div_x, div_y, rho, ux, uy;
  logic div_busy = 0, div_valid = 0, div_dbz = 0, div_ovf = 0;
  logic [W-1:0] div_q = '0;
  int n_chk = 0, n_fail = 0;
  int div_lat = 3, cnt = 0, starts = 0;
  bit force_dbz = 0, pending = 0, stale = 0, unstable = 0;
  logic [W-1:0] cx = '0, cy = '0;
  int ext [9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  int eyt [9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
  logic [W-1:0] obs_rho, obs_ux, obs_uy;
  bit obs_dbz, obs_ovf;
  int obs_starts;

  lbm_moments dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .f_in(f_in),
    .div_start(div_start), .div_x(div_x), .div_y(div_y), .div_busy(div_busy),
    .div_valid(div_valid), .div_dbz(div_dbz), .div_ovf(div_ovf), .div_q(div_q),
    .out_valid(out_valid), .out_ready(out_ready), .rho(rho), .ux(ux), .uy(uy),
    .err_dbz(err_dbz), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  function automatic longint sat32(input longint v, output bit o);
    o = v > 64'sd2147483647 || v < -64'sd2147483648;
    return v > 64'sd2147483647 ? 64'sd2147483647 : v < -64'sd2147483648 ? -64'sd2147483648 : v;
  endfunction

  // Q8.24 quotient x/y truncated toward zero, saturated to the word range
  function automatic logic [W-1:0] qdiv(input logic [W-1:0] x, input logic [W-1:0] y, output bit o, output bit z);
    longint n;
    n = longint'($signed(x)) * 64'sd16777216;
    z = y == '0;
    o = 0;
    if (z) return '0;
    return W'(sat32(n / longint'($signed(y)), o));
  endfunction

  // divider stand-in: fixed latency, busy while working, ignores reset of the DUT
  always @(posedge clk) begin : divm
    logic [W-1:0] q;
    bit o, z;
    div_valid <= 0;
    div_dbz <= 0;
    div_ovf <= 0;
    if (rst) stale <= 1;
    if (pending) begin
      if (!stale && !rst && (div_x !== cx || div_y !== cy)) unstable <= 1;
      if (cnt <= 1) begin
        pending <= 0;
        div_busy <= 0;
        div_valid <= 1;
        if (force_dbz) begin
          div_q <= 32'h5A5A5A5A;
          div_dbz <= 1;
        end else begin
          q = qdiv(cx, cy, o, z);
          div_q <= q;
          div_ovf <= o;
          div_dbz <= z;
        end
      end else cnt <= cnt - 1;
    end else if (div_start && !rst) begin
      pending <= 1;
      div_busy <= 1;
      cx <= div_x;
      cy <= div_y;
      cnt <= div_lat;
      starts <= starts + 1;
      stale <= 0;
    end
  end

  task automatic model(input logic [W-1:0] f [9], output logic [W-1:0] r, output logic [W-1:0] x,
                       output logic [W-1:0] y, output bit dz, output bit ov, output int ns);
    longint sr, sx, sy;
    bit o1, o2, o3, z;
    logic [W-1:0] cmx, cmy;
    sr = 0; sx = 0; sy = 0;
    for (int i = 0; i < 9; i++) begin
      sr += longint'($signed(f[i]));
      sx += ext[i] * longint'($signed(f[i]));
      sy += eyt[i] * longint'($signed(f[i]));
    end
    r = W'(sat32(sr, o1));
    cmx = W'(sat32(sx, o2));
    cmy = W'(sat32(sy, o3));
    ov = o1 | o2 | o3;
    x = '0; y = '0; dz = 0; ns = 0;
    if (r == '0) dz = 1;
    else begin
      ns = 2;
      if (force_dbz) dz = 1;
      else begin
        x = qdiv(cmx, r, o1, z);
        y = qdiv(cmy, r, o2, z);
        ov = ov | o1 | o2;
      end
    end
  endtask

  task automatic send(input logic [W-1:0] f [9], input bit bub);
    for (int i = 0; i < 9; i++) begin
      if (bub) repeat ($urandom_range(0, 2)) begin in_valid = 0; @(negedge clk); end
      in_valid = 1;
      f_in = f[i];
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  task automatic run_burst(input logic [W-1:0] f [9], input bit bub);
    int s0, k;
    s0 = starts;
    k = 0;
    send(f, bub);
    while (!out_valid && k < 200) begin @(negedge clk); k++; end
    n_chk++;
    if (!out_valid) begin n_fail++; $display("FAIL burst_timeout: out_valid got 0 want 1 after %0d cycles", k); end
    obs_rho = rho; obs_ux = ux; obs_uy = uy; obs_dbz = err_dbz; obs_ovf = err_ovf;
    obs_starts = starts - s0;
  endtask

  task automatic ack();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  function automatic logic [W-1:0] rnd_f();
    logic [W-1:0] v;
    int m;
    v = $urandom;
    m = $urandom_range(0, 9);
    return m == 0 ? v : m == 1 ? '0 : {{5{v[26]}}, v[26:0]};
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({in_ready, out_valid, div_start, err_dbz, err_ovf} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctl: got %b want 10000", {in_ready, out_valid, div_start, err_dbz, err_ovf});
    end
    n_chk++;
    if ({div_x, div_y, rho, ux, uy} !== '0) begin
      n_fail++; $display("FAIL reset_data: got x=%h y=%h rho=%h ux=%h uy=%h want all 0", div_x, div_y, rho, ux, uy);
    end
    rst = 0;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_rest();
    logic [W-1:0] f [9] = '{default: '0};
    f[0] = 32'h00800000;
    run_burst(f, 0);
    n_chk++;
    if (obs_rho !== 32'h00800000) begin n_fail++; $display("FAIL rest_rho: got %h want 00800000", obs_rho); end
    n_chk++;
    if ({obs_ux, obs_uy} !== '0) begin n_fail++; $display("FAIL rest_u: got %h %h want 0 0", obs_ux, obs_uy); end
    n_chk++;
    if ({obs_dbz, obs_ovf} !== 2'b00) begin n_fail++; $display("FAIL rest_flags: got %b want 00", {obs_dbz, obs_ovf}); end
    n_chk++;
    if (obs_starts !== 2) begin n_fail++; $display("FAIL rest_starts: got %0d want 2", obs_starts); end
    ack();
  endtask

  task automatic test_half();
    logic [W-1:0] f [9] = '{default: '0};
    f[0] = 32'h00800000;
    f[1] = 32'h00800000;
    run_burst(f, 1);
    n_chk++;
    if (obs_rho !== 32'h01000000) begin n_fail++; $display("FAIL half_rho: got %h want 01000000", obs_rho); end
    n_chk++;
    if (obs_ux !== 32'h00800000) begin n_fail++; $display("FAIL half_ux: got %h want 00800000", obs_ux); end
    n_chk++;
    if (obs_uy !== '0 || {obs_dbz, obs_ovf} !== 2'b00) begin
      n_fail++; $display("FAIL half_uy_flags: got %h %b want 0 00", obs_uy, {obs_dbz, obs_ovf});
    end
    ack();
  endtask

  task automatic test_zero();
    logic [W-1:0] f [9] = '{default: '0};
    run_burst(f, 0);
    n_chk++;
    if ({obs_dbz, obs_ovf} !== 2'b10) begin n_fail++; $display("FAIL zero_flags: got %b want 10", {obs_dbz, obs_ovf}); end
    n_chk++;
    if ({obs_rho, obs_ux, obs_uy} !== '0) begin n_fail++; $display("FAIL zero_out: got %h %h %h want 0", obs_rho, obs_ux, obs_uy); end
    n_chk++;
    if (obs_starts !== 0) begin n_fail++; $display("FAIL zero_starts: got %0d want 0", obs_starts); end
    ack();
  endtask

  task automatic test_sat();
    logic [W-1:0] f [9] = '{default: 32'h7F000000};
    run_burst(f, 0);
    n_chk++;
    if (obs_rho !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL sat_rho: got %h want 7fffffff", obs_rho); end
    n_chk++;
    if ({obs_dbz, obs_ovf} !== 2'b01) begin n_fail++; $display("FAIL sat_flags: got %b want 01", {obs_dbz, obs_ovf}); end
    n_chk++;
    if ({obs_ux, obs_uy} !== '0) begin n_fail++; $display("FAIL sat_u: got %h %h want 0 0", obs_ux, obs_uy); end
    ack();
  endtask

  task automatic test_div_dbz();
    logic [W-1:0] f [9] = '{default: '0};
    f[0] = 32'h00800000;
    f[2] = 32'h00400000;
    force_dbz = 1;
    run_burst(f, 0);
    force_dbz = 0;
    n_chk++;
    if ({obs_ux, obs_uy, obs_dbz} !== {64'h0, 1'b1}) begin
      n_fail++; $display("FAIL div_dbz: got ux=%h uy=%h dbz=%b want 0 0 1", obs_ux, obs_uy, obs_dbz);
    end
    ack();
  endtask

  task automatic test_random();
    logic [W-1:0] f [9];
    logic [W-1:0] er, ex, ey;
    bit ed, eo;
    int es;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 9; i++) f[i] = rnd_f();
      div_lat = $urandom_range(1, 6);
      model(f, er, ex, ey, ed, eo, es);
      run_burst(f, 1);
      n_chk++;
      if (obs_rho !== er || obs_ux !== ex || obs_uy !== ey || obs_dbz !== ed || obs_ovf !== eo || obs_starts !== es) begin
        n_fail++;
        $display("FAIL random_%0d: got rho=%h ux=%h uy=%h dbz=%b ovf=%b starts=%0d want %h %h %h %b %b %0d",
                 t, obs_rho, obs_ux, obs_uy, obs_dbz, obs_ovf, obs_starts, er, ex, ey, ed, eo, es);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ack();
    end
    n_chk++;
    if (unstable) begin n_fail++; $display("FAIL operand_stability: got unstable=1 want 0"); end
  endtask

  task automatic test_reset_mid_div();
    logic [W-1:0] f [9] = '{default: '0};
    int k, s0;
    bit bad;
    f[0] = 32'h00800000;
    f[1] = 32'h00800000;
    div_lat = 20;
    s0 = starts;
    k = 0;
    send(f, 0);
    while (starts == s0 && k < 50) begin @(negedge clk); k++; end
    n_chk++;
    if (starts == s0) begin n_fail++; $display("FAIL middiv_start: got no div_start want 1"); end
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid || !in_ready || div_start || err_dbz || err_ovf || {rho, ux, uy, div_x, div_y} != '0) bad = 1;
    end
    n_chk++;
    if (bad) begin n_fail++; $display("FAIL middiv_reset_hold: got disturbed outputs want reset values, ux=%h rho=%h", ux, rho); end
    div_lat = 3;
    run_burst(f, 0);
    n_chk++;
    if (obs_rho !== 32'h01000000 || obs_ux !== 32'h00800000 || obs_uy !== '0 || obs_starts !== 2) begin
      n_fail++; $display("FAIL middiv_next: got rho=%h ux=%h uy=%h starts=%0d want 01000000 00800000 0 2", obs_rho, obs_ux, obs_uy, obs_starts);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] f [9];
    logic [W-1:0] er, ex, ey;
    bit ed, eo, bad;
    int es;
    for (int i = 0; i < 9; i++) f[i] = rnd_f();
    model(f, er, ex, ey, ed, eo, es);
    run_burst(f, 0);
    bad = 0;
    repeat (10) begin
      in_valid = 1;
      f_in = $urandom;
      @(negedge clk);
      if (!out_valid || in_ready || rho !== obs_rho || ux !== obs_ux || uy !== obs_uy || err_dbz !== obs_dbz || err_ovf !== obs_ovf) bad = 1;
    end
    in_valid = 0;
    n_chk++;
    if (bad) begin n_fail++; $display("FAIL hold_stable: got changing outputs or in_ready=1 while waiting, want stable"); end
    n_chk++;
    if (obs_rho !== er || obs_ux !== ex || obs_uy !== ey || obs_dbz !== ed || obs_ovf !== eo) begin
      n_fail++; $display("FAIL hold_result: got %h %h %h %b %b want %h %h %h %b %b", obs_rho, obs_ux, obs_uy, obs_dbz, obs_ovf, er, ex, ey, ed, eo);
    end
    ack();
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL after_ack: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    for (int i = 0; i < 9; i++) f[i] = rnd_f();
    model(f, er, ex, ey, ed, eo, es);
    run_burst(f, 0);
    n_chk++;
    if (obs_rho !== er || obs_ux !== ex || obs_uy !== ey || obs_dbz !== ed || obs_ovf !== eo || obs_starts !== es) begin
      n_fail++; $display("FAIL b2b_next: got %h %h %h %b %b %0d want %h %h %h %b %b %0d",
                         obs_rho, obs_ux, obs_uy, obs_dbz, obs_ovf, obs_starts, er, ex, ey, ed, eo, es);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_rest();
    test_half();
    test_zero();
    test_sat();
    test_div_dbz();
    test_random();
    test_reset_mid_div();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
